// File: rtl/dump_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : dump_datapath_if
//  Description : Request, squeezed-block and output-word signals of the
//                dump datapath.
//                slave  = datapath side, master = controller / consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface dump_datapath_if #(
  parameter int W    = 64,
  parameter int RATE = 1344
);
  // request
  logic            start;
  logic [31:0]     output_size_in;
  logic [1:0]      operation_mode_in;
  logic            done;
  // squeezed block input
  logic            block_valid;
  logic [RATE-1:0] block_in;
  logic            block_ready;
  // output word stream
  logic [W-1:0]    data_out;
  logic            data_out_valid;
  logic            data_out_ready;
  logic            data_out_last;

  modport slave (
    input  start, output_size_in, operation_mode_in,
    input  block_valid, block_in, data_out_ready,
    output block_ready, data_out, data_out_valid, data_out_last, done
  );

  modport master (
    output start, output_size_in, operation_mode_in,
    output block_valid, block_in, data_out_ready,
    input  block_ready, data_out, data_out_valid, data_out_last, done
  );
endinterface
`default_nettype wire

// File: rtl/dump_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : dump_datapath
//  Description : Streams the rate part of squeezed Keccak states as
//                byte-swapped 64-bit words until the requested byte count is
//                reached, requesting a new squeeze at each block boundary.
//                The final word is truncated to its valid bytes (MSB side).
//  Revision    : 1.0  initial release
// ============================================================================
module dump_datapath #(
  parameter int         W                 = 64,
  parameter int         RATE              = 1344,
  parameter logic [1:0] SHAKE128_MODE_VEC = 2'b00,
  parameter logic [1:0] SHAKE256_MODE_VEC = 2'b01
) (
  input  wire logic       clk,
  input  wire logic       rst,
  dump_datapath_if.slave  bus
);

  // Lane counts: SHAKE128 uses the full rate, SHAKE256 only 1088 bits of it.
  localparam logic [4:0] LAST_IDX_128 = 5'(RATE / W - 1);
  localparam logic [4:0] LAST_IDX_256 = 5'(1088 / W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [RATE-1:0] piso;        // lane 0 is always the word being presented
  logic [4:0]      word_cnt;    // lane index within the current block
  logic [4:0]      last_idx;    // index of the final lane of a block, per mode
  logic [28:0]     bytes_rem;   // bytes still owed to the consumer
  logic            done_r;

  logic [28:0]     byte_cnt_in;
  logic            is_last;
  logic [7:0]      byte_keep;
  logic [W-1:0]    word_out;

  assign byte_cnt_in = bus.output_size_in[31:3];
  assign is_last     = (bytes_rem <= 29'd8);

  // Endian switch: lane byte k goes to output byte position k counted from
  // the MSB. On the final word only the first bytes_rem bytes survive.
  for (genvar k = 0; k < 8; k++) begin : g_byte
    assign byte_keep[k] = !is_last || (4'(k) < bytes_rem[3:0]);
    assign word_out[W-1-8*k -: 8] = byte_keep[k] ? piso[8*k +: 8] : 8'h00;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start && (byte_cnt_in != 29'd0)) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.block_valid) begin
          state_nxt = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (bus.data_out_ready) begin
          if (is_last) begin
            state_nxt = ST_IDLE;
          end else if (word_cnt == last_idx) begin
            state_nxt = ST_WAIT;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs follow the state; data is forced to 0 outside DUMP.
  always_comb begin
    bus.block_ready    = 1'b0;
    bus.data_out_valid = 1'b0;
    bus.data_out_last  = 1'b0;
    bus.data_out       = '0;
    case (state)
      ST_WAIT: bus.block_ready = 1'b1;
      ST_DUMP: begin
        bus.data_out_valid = 1'b1;
        bus.data_out_last  = is_last;
        bus.data_out       = word_out;
      end
      default: ;
    endcase
  end

  assign bus.done = done_r;

  // Request latch, block load, lane shifting and byte accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      piso      <= '0;
      word_cnt  <= '0;
      last_idx  <= '0;
      bytes_rem <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (byte_cnt_in == 29'd0) begin
              done_r <= 1'b1;
            end else begin
              bytes_rem <= byte_cnt_in;
              last_idx  <= (bus.operation_mode_in == SHAKE256_MODE_VEC) ?
                           LAST_IDX_256 : LAST_IDX_128;
            end
          end
        end
        ST_WAIT: begin
          if (bus.block_valid) begin
            piso     <= bus.block_in;
            word_cnt <= '0;
          end
        end
        ST_DUMP: begin
          if (bus.data_out_ready) begin
            piso      <= {{W{1'b0}}, piso[RATE-1:W]};
            word_cnt  <= word_cnt + 5'd1;
            bytes_rem <= is_last ? 29'd0 : (bytes_rem - 29'd8);
            if (is_last) begin
              done_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dump_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dump_datapath
//  Description : Directed self-checking bench for dump_datapath.
//                Block b, lane i = 0x0706050403020100 + i + (b << 56), so the
//                byte-swapped word is {i, 01..06, 07+b}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dump_datapath;

  localparam logic [1:0] M128 = 2'b00;
  localparam logic [1:0] M256 = 2'b01;
  localparam logic [1:0] MOTH = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dump_datapath_if #(.W(64), .RATE(1344)) bus ();

  dump_datapath #(.W(64), .RATE(1344)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int blk_acc   = 0;

  logic [63:0] got_w[$];
  bit          got_l[$];
  int          done_cnt, done_cyc, last_cyc, done_tail;
  int          stall_err, br_cycles, blk_start;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  function automatic logic [1343:0] make_block(input int b);
    logic [1343:0] v;
    for (int i = 0; i < 21; i++)
      v[64*i +: 64] = 64'h0706050403020100 + 64'(i) + (64'(b) << 56);
    return v;
  endfunction

  function automatic logic [63:0] exp_word(input int b, input int i);
    logic [7:0] lo;
    lo = 8'h07 + 8'(b);
    return {8'(i), 48'h010203040506, lo};
  endfunction

  // Block source: always offering, contents tagged by accepted-block number.
  always_comb bus.block_in = make_block(blk_acc);
  always @(posedge clk)
    if (!rst && bus.block_valid && bus.block_ready) blk_acc <= blk_acc + 1;

  // Issue one request (called at a negedge) and collect everything until done.
  task automatic run_req(input logic [31:0] size, input logic [1:0] mode, input bit rnd);
    bit          stall_prev, fin;
    logic [63:0] prev_d;
    logic        prev_l;
    got_w.delete(); got_l.delete();
    done_cnt = 0; done_cyc = -1; last_cyc = -100; stall_err = 0; br_cycles = 0;
    blk_start = blk_acc; stall_prev = 0; fin = 0; prev_d = '0; prev_l = 1'b0;
    bus.start = 1'b1; bus.output_size_in = size; bus.operation_mode_in = mode;
    @(negedge clk);
    bus.start = 1'b0;
    bus.output_size_in = $urandom;
    bus.operation_mode_in = (mode == M256) ? M128 : M256;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      bus.data_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.block_ready) br_cycles++;
      if (stall_prev && (bus.data_out !== prev_d || bus.data_out_last !== prev_l ||
                         !bus.data_out_valid)) stall_err++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; fin = 1; end
      if (bus.data_out_valid && bus.data_out_ready) begin
        got_w.push_back(bus.data_out);
        got_l.push_back(bus.data_out_last);
        last_cyc = cyc;
      end
      stall_prev = bus.data_out_valid && !bus.data_out_ready;
      prev_d = bus.data_out; prev_l = bus.data_out_last;
      @(negedge clk);
    end
    done_tail = int'(bus.done);
    bus.data_out_ready = 1'b1;
  endtask

  // Compare collected words and last flags against the block model.
  task automatic check_words(input string tag, input int nbytes, input int wpb);
    int nw, bad_l;
    nw = (nbytes + 7) / 8;
    bad_l = 0;
    check({tag, " count"}, 64'(got_w.size()), 64'(nw));
    for (int n = 0; n < got_w.size() && n < nw; n++) begin
      logic [63:0] e;
      int r;
      e = exp_word(blk_start + n / wpb, n % wpb);
      r = nbytes - 8 * n;
      if (r < 8) e = e & ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * r));
      check($sformatf("%s w%0d", tag, n), got_w[n], e);
      if (got_l[n] != (n == nw - 1)) bad_l++;
    end
    check({tag, " last flags"}, 64'(bad_l), 64'd0);
    check({tag, " done count"}, 64'(done_cnt), 64'd1);
    check({tag, " done gap"}, 64'(done_cyc - last_cyc), 64'd1);
    check({tag, " done pulse"}, 64'(done_tail), 64'd0);
  endtask

  initial begin
    int n;
    bit hit;
    rst = 1'b1;
    bus.start = 1'b0; bus.output_size_in = '0; bus.operation_mode_in = M128;
    bus.block_valid = 1'b1; bus.data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst data_out", bus.data_out, 64'd0);
    check("rst valid", 64'(bus.data_out_valid), 64'd0);
    check("rst last", 64'(bus.data_out_last), 64'd0);
    check("rst block_ready", 64'(bus.block_ready), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    // SHAKE128, 256 bits -> 4 words from one block
    run_req(32'd256, M128, 1'b0);
    check("s128 word0", (got_w.size() > 0) ? got_w[0] : 64'hX, 64'h0001020304050607);
    check_words("s128", 32, 21);
    check("s128 blocks", 64'(blk_acc - blk_start), 64'd1);
    check("s128 block_ready cycles", 64'(br_cycles), 64'd1);

    // SHAKE256, 17 words + 1 -> second squeeze, mode change after start ignored
    run_req(32'd1152, M256, 1'b0);
    check_words("s256", 144, 17);
    check("s256 blocks", 64'(blk_acc - blk_start), 64'd2);
    check("s256 block_ready cycles", 64'(br_cycles), 64'd2);

    // 20 bits -> 2 bytes, truncated single word
    run_req(32'd20, M128, 1'b0);
    check("part2 word", (got_w.size() > 0) ? got_w[0] : 64'hX, 64'h0001_0000_0000_0000);
    check_words("part2", 2, 21);

    // 111 bits -> 13 bytes: second word keeps 5 bytes
    run_req(32'd111, M128, 1'b0);
    check("part13 word1", (got_w.size() > 1) ? got_w[1] : 64'hX, 64'h0101_0203_0400_0000);
    check_words("part13", 13, 21);

    // unknown mode encoding behaves as SHAKE128 (21 lanes)
    run_req(32'd1408, MOTH, 1'b0);
    check_words("mode11", 176, 21);
    check("mode11 blocks", 64'(blk_acc - blk_start), 64'd2);

    // random backpressure, three full SHAKE128 blocks
    run_req(32'd4032, M128, 1'b1);
    check_words("bp", 504, 21);
    check("bp stalls stable", 64'(stall_err), 64'd0);
    check("bp blocks", 64'(blk_acc - blk_start), 64'd3);

    // zero-length request
    run_req(32'd7, M128, 1'b0);
    check("zero done cycle", 64'(done_cyc), 64'd0);
    check("zero done pulse", 64'(done_tail), 64'd0);
    check("zero block_ready", 64'(br_cycles), 64'd0);
    check("zero words", 64'(got_w.size()), 64'd0);

    // reset while word 5 of a block is presented
    blk_start = blk_acc;
    bus.start = 1'b1; bus.output_size_in = 32'd1344; bus.operation_mode_in = M128;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; hit = 0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      if (bus.data_out_valid && n == 5) hit = 1;
      else begin
        if (bus.data_out_valid && bus.data_out_ready) n++;
        @(negedge clk);
      end
    end
    check("mid word5 reached", 64'(hit), 64'd1);
    check("mid word5 data", bus.data_out, exp_word(blk_start, 5));
    rst = 1'b1;
    @(negedge clk);
    check("mid rst data_out", bus.data_out, 64'd0);
    check("mid rst valid", 64'(bus.data_out_valid), 64'd0);
    check("mid rst last", 64'(bus.data_out_last), 64'd0);
    check("mid rst block_ready", 64'(bus.block_ready), 64'd0);
    check("mid rst done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    run_req(32'd256, M128, 1'b0);
    check_words("after rst", 32, 21);
    check("after rst blocks", 64'(blk_acc - blk_start), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
